// File: rtl/sys_bus_interconnect.sv
// Shared system bus: arbitrates N hosts onto one bus, decodes to M devices,
// and routes the single-cycle-latency response back to the granted host.
module sys_bus_interconnect #(
  parameter int unsigned NrHosts       = 3,
  parameter int unsigned NrDevices     = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter bit          ArbRoundRobin = 1'b0,
  parameter logic [NrDevices*AddrWidth-1:0] DevBase = '0,
  parameter logic [NrDevices*AddrWidth-1:0] DevMask = {NrDevices{AddrWidth'(32'hFFFF)}}
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_sys_ni,
  input  logic [NrHosts-1:0]             host_req_i,
  input  logic [NrHosts-1:0]             host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0] host_be_i,
  input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
  input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]             host_gnt_o,
  output logic [NrHosts-1:0]             host_rvalid_o,
  output logic [NrHosts-1:0]             host_err_o,
  output logic [NrHosts*DataWidth-1:0]   host_rdata_o,
  output logic [NrDevices-1:0]           dev_req_o,
  output logic                           dev_we_o,
  output logic [DataWidth/8-1:0]         dev_be_o,
  output logic [AddrWidth-1:0]           dev_addr_o,
  output logic [DataWidth-1:0]           dev_wdata_o,
  input  logic [NrDevices*DataWidth-1:0] dev_rdata_i,
  input  logic [NrDevices-1:0]           dev_err_i
);

  localparam int unsigned BeW   = DataWidth / 8;
  localparam int unsigned HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic [HostW-1:0]     r_rr;
  logic                 r_rsp_valid;
  logic [HostW-1:0]     r_rsp_host;
  logic [DevW-1:0]      r_rsp_dev;
  logic                 r_rsp_miss;

  logic                 w_gnt_valid;
  logic [HostW-1:0]     w_gnt_idx;
  logic                 w_we;
  logic [BeW-1:0]       w_be;
  logic [AddrWidth-1:0] w_addr;
  logic [DataWidth-1:0] w_wdata;
  logic                 w_hit;
  logic [DevW-1:0]      w_dev_idx;
  logic [DataWidth-1:0] w_dev_rdata;
  logic                 w_dev_err;
  int                   w_h;

  // Arbitration: descending scan so the last (lowest) candidate wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_h         = 0;
    for (int off = int'(NrHosts) - 1; off >= 0; off--) begin
      if (ArbRoundRobin) begin
        w_h = int'(r_rr) + off;
        if (w_h >= int'(NrHosts)) w_h = w_h - int'(NrHosts);
      end else begin
        w_h = off;
      end
      if (host_req_i[w_h]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = HostW'(w_h);
      end
    end
  end

  // Grant vector and request mux onto the shared bus.
  always_comb begin
    host_gnt_o = '0;
    w_we       = 1'b0;
    w_be       = '0;
    w_addr     = '0;
    w_wdata    = '0;
    for (int h = 0; h < int'(NrHosts); h++) begin
      if (w_gnt_valid && (w_gnt_idx == HostW'(h))) begin
        host_gnt_o[h] = 1'b1;
        w_we          = host_we_i[h];
        w_be          = host_be_i[h*BeW +: BeW];
        w_addr        = host_addr_i[h*AddrWidth +: AddrWidth];
        w_wdata       = host_wdata_i[h*DataWidth +: DataWidth];
      end
    end
  end

  // Address decode; lowest matching device wins on overlap.
  always_comb begin
    w_hit     = 1'b0;
    w_dev_idx = '0;
    dev_req_o = '0;
    for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
      if ((w_addr & ~DevMask[d*AddrWidth +: AddrWidth]) == DevBase[d*AddrWidth +: AddrWidth]) begin
        w_hit     = 1'b1;
        w_dev_idx = DevW'(d);
      end
    end
    if (w_gnt_valid && w_hit) dev_req_o[w_dev_idx] = 1'b1;
  end

  assign dev_we_o    = w_we;
  assign dev_be_o    = w_be;
  assign dev_addr_o  = w_addr;
  assign dev_wdata_o = w_wdata;

  // Response tracking and round-robin pointer.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_rr        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_host  <= '0;
      r_rsp_dev   <= '0;
      r_rsp_miss  <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_rsp_host <= w_gnt_idx;
        r_rsp_dev  <= w_hit ? w_dev_idx : '0;
        r_rsp_miss <= ~w_hit;
        r_rr       <= (w_gnt_idx == HostW'(NrHosts - 1)) ? '0 : HostW'(w_gnt_idx + 1'b1);
      end
    end
  end

  // Select the responding device's data and error.
  always_comb begin
    w_dev_rdata = '0;
    w_dev_err   = 1'b0;
    for (int d = 0; d < int'(NrDevices); d++) begin
      if (r_rsp_dev == DevW'(d)) begin
        w_dev_rdata = dev_rdata_i[d*DataWidth +: DataWidth];
        w_dev_err   = dev_err_i[d];
      end
    end
  end

  // Route the response to the host that was granted last cycle only.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    for (int h = 0; h < int'(NrHosts); h++) begin
      if (r_rsp_valid && (r_rsp_host == HostW'(h))) begin
        host_rvalid_o[h]                       = 1'b1;
        host_err_o[h]                          = r_rsp_miss | w_dev_err;
        host_rdata_o[h*DataWidth +: DataWidth] = r_rsp_miss ? '0 : w_dev_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// Directed bench: fixed-priority and round-robin instances share one stimulus set.
module tb_sys_bus_interconnect;

  localparam logic [31:0] D0 = 32'hA5A5_0000;
  localparam logic [31:0] D1 = 32'h5A5A_1111;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req, we;
  logic [11:0] be;
  logic [95:0] addr, wdata;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_err;

  logic [2:0]  f_gnt, f_rvalid, f_err, r_gnt, r_rvalid, r_err;
  logic [95:0] f_rdata, r_rdata;
  logic [1:0]  f_dev_req, r_dev_req;
  logic        f_dev_we, r_dev_we;
  logic [3:0]  f_dev_be, r_dev_be;
  logic [31:0] f_dev_addr, r_dev_addr, f_dev_wdata, r_dev_wdata;
  logic [95:0] exp_rd;

  int total = 0;
  int bad   = 0;

  sys_bus_interconnect #(
    .NrHosts(3), .NrDevices(2), .DataWidth(32), .AddrWidth(32), .ArbRoundRobin(1'b0),
    .DevBase(64'h1A11_0000_0000_0000), .DevMask(64'h0000_FFFF_0000_FFFF)
  ) u_fixed (
    .clk_sys_i(clk), .rst_sys_ni(rst_n),
    .host_req_i(req), .host_we_i(we), .host_be_i(be), .host_addr_i(addr), .host_wdata_i(wdata),
    .host_gnt_o(f_gnt), .host_rvalid_o(f_rvalid), .host_err_o(f_err), .host_rdata_o(f_rdata),
    .dev_req_o(f_dev_req), .dev_we_o(f_dev_we), .dev_be_o(f_dev_be), .dev_addr_o(f_dev_addr),
    .dev_wdata_o(f_dev_wdata), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err)
  );

  sys_bus_interconnect #(
    .NrHosts(3), .NrDevices(2), .DataWidth(32), .AddrWidth(32), .ArbRoundRobin(1'b1),
    .DevBase(64'h1A11_0000_0000_0000), .DevMask(64'h0000_FFFF_0000_FFFF)
  ) u_rr (
    .clk_sys_i(clk), .rst_sys_ni(rst_n),
    .host_req_i(req), .host_we_i(we), .host_be_i(be), .host_addr_i(addr), .host_wdata_i(wdata),
    .host_gnt_o(r_gnt), .host_rvalid_o(r_rvalid), .host_err_o(r_err), .host_rdata_o(r_rdata),
    .dev_req_o(r_dev_req), .dev_we_o(r_dev_we), .dev_be_o(r_dev_be), .dev_addr_o(r_dev_addr),
    .dev_wdata_o(r_dev_wdata), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; be = '0; addr = '0; wdata = '0; dev_err = '0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (f_gnt !== 3'b000) begin bad++; $display("FAIL rst_gnt got=%b exp=000", f_gnt); end
    total++; if (f_dev_req !== 2'b00) begin bad++; $display("FAIL rst_dev_req got=%b exp=00", f_dev_req); end
    total++; if (f_dev_addr !== 32'h0) begin bad++; $display("FAIL rst_dev_addr got=%h exp=0", f_dev_addr); end
    total++; if (f_rvalid !== 3'b000 || r_rvalid !== 3'b000) begin bad++; $display("FAIL rst_rvalid got=%b/%b exp=000", f_rvalid, r_rvalid); end
    total++; if (f_rdata !== 96'h0 || f_err !== 3'b000) begin bad++; $display("FAIL rst_rdata_err got=%h/%b exp=0/000", f_rdata, f_err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    idle_inputs();
    req  = 3'b111;
    addr = {32'h10, 32'h10, 32'h10};
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (r_gnt !== 3'(1 << (c % 3))) begin bad++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, r_gnt, 3'(1 << (c % 3))); end
      if (c > 0) begin
        exp_rd = 96'(D0) << (32 * ((c - 1) % 3));
        total++;
        if (r_rvalid !== 3'(1 << ((c - 1) % 3)) || r_rdata !== exp_rd) begin
          bad++; $display("FAIL rr_rsp c=%0d got=%b/%h exp=%b/%h", c, r_rvalid, r_rdata, 3'(1 << ((c - 1) % 3)), exp_rd);
        end
      end
      tick();
    end
    req = '0;
    #1;
    total++; if (r_rvalid !== 3'b100 || r_gnt !== 3'b000) begin bad++; $display("FAIL rr_last got=%b/%b exp=100/000", r_rvalid, r_gnt); end
    tick();
  endtask

  task automatic test_fixed_priority();
    idle_inputs();
    req  = 3'b111;
    addr = {32'h10, 32'h10, 32'h10};
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (f_gnt !== 3'b001 || f_dev_req !== 2'b01 || f_dev_addr !== 32'h10) begin
        bad++; $display("FAIL fp_gnt c=%0d got=%b/%b/%h exp=001/01/10", c, f_gnt, f_dev_req, f_dev_addr);
      end
      if (c > 0) begin
        total++;
        if (f_rvalid !== 3'b001 || f_rdata !== 96'(D0) || f_err !== 3'b000) begin
          bad++; $display("FAIL fp_rsp c=%0d got=%b/%h/%b exp=001/%h/000", c, f_rvalid, f_rdata, f_err, D0);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_unmapped();
    idle_inputs();
    req = 3'b010;
    addr[63:32] = 32'h2000_0000;
    #1;
    total++; if (f_gnt !== 3'b010 || f_dev_req !== 2'b00) begin bad++; $display("FAIL um_req got=%b/%b exp=010/00", f_gnt, f_dev_req); end
    tick();
    idle_inputs();
    #1;
    total++; if (f_rvalid !== 3'b010 || f_err !== 3'b010) begin bad++; $display("FAIL um_rsp got=%b/%b exp=010/010", f_rvalid, f_err); end
    total++; if (f_rdata !== 96'h0) begin bad++; $display("FAIL um_rdata got=%h exp=0", f_rdata); end
    tick();
  endtask

  task automatic test_decode_write();
    idle_inputs();
    req = 3'b100;
    we  = 3'b100;
    be[11:8]     = 4'b1111;
    addr[95:64]  = 32'h1A11_0004;
    wdata[95:64] = 32'hDEAD_BEEF;
    #1;
    total++; if (f_gnt !== 3'b100 || f_dev_req !== 2'b10) begin bad++; $display("FAIL dw_req got=%b/%b exp=100/10", f_gnt, f_dev_req); end
    total++; if (f_dev_addr !== 32'h1A11_0004 || f_dev_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dw_bus got=%h/%h exp=1a110004/deadbeef", f_dev_addr, f_dev_wdata); end
    total++; if (f_dev_we !== 1'b1 || f_dev_be !== 4'hF) begin bad++; $display("FAIL dw_we_be got=%b/%h exp=1/f", f_dev_we, f_dev_be); end
    tick();
    idle_inputs();
    #1;
    total++; if (f_rvalid !== 3'b100 || f_err !== 3'b000) begin bad++; $display("FAIL dw_rsp got=%b/%b exp=100/000", f_rvalid, f_err); end
    total++; if (f_rdata !== {D1, 64'h0}) begin bad++; $display("FAIL dw_rdata got=%h exp=%h", f_rdata, {D1, 64'h0}); end
    tick();
  endtask

  task automatic test_dev_error();
    idle_inputs();
    req = 3'b001;
    addr[31:0] = 32'h10;
    tick();
    idle_inputs();
    dev_err = 2'b01;
    #1;
    total++; if (f_rvalid !== 3'b001 || f_err !== 3'b001) begin bad++; $display("FAIL de_rsp got=%b/%b exp=001/001", f_rvalid, f_err); end
    tick();
    dev_err = '0;
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    req = 3'b001;
    addr[31:0] = 32'h10;
    #1;
    total++; if (f_gnt !== 3'b001 || f_dev_req !== 2'b01) begin bad++; $display("FAIL bb_c0 got=%b/%b exp=001/01", f_gnt, f_dev_req); end
    tick();
    req = 3'b010;
    addr[63:32] = 32'h1A11_0000;
    #1;
    total++; if (f_gnt !== 3'b010 || f_dev_req !== 2'b10) begin bad++; $display("FAIL bb_c1_gnt got=%b/%b exp=010/10", f_gnt, f_dev_req); end
    total++; if (f_rvalid !== 3'b001 || f_rdata !== 96'(D0)) begin bad++; $display("FAIL bb_c1_rsp got=%b/%h exp=001/%h", f_rvalid, f_rdata, 96'(D0)); end
    tick();
    idle_inputs();
    #1;
    total++; if (f_gnt !== 3'b000 || f_dev_req !== 2'b00 || f_dev_addr !== 32'h0) begin bad++; $display("FAIL bb_c2_idle got=%b/%b/%h exp=000/00/0", f_gnt, f_dev_req, f_dev_addr); end
    total++; if (f_rvalid !== 3'b010 || f_rdata !== {32'h0, D1, 32'h0}) begin bad++; $display("FAIL bb_c2_rsp got=%b/%h exp=010/%h", f_rvalid, f_rdata, {32'h0, D1, 32'h0}); end
    tick();
    #1;
    total++; if (f_rvalid !== 3'b000) begin bad++; $display("FAIL bb_c3_rsp got=%b exp=000", f_rvalid); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    req = 3'b010;
    addr[63:32] = 32'h10;
    #1;
    total++; if (r_gnt !== 3'b010) begin bad++; $display("FAIL rm_gnt got=%b exp=010", r_gnt); end
    tick();
    idle_inputs();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (r_rvalid !== 3'b000 || f_rvalid !== 3'b000) begin bad++; $display("FAIL rm_in_rst c=%0d got=%b/%b exp=000", c, r_rvalid, f_rvalid); end
      tick();
    end
    rst_n = 1'b1;
    #1;
    total++; if (r_rvalid !== 3'b000 || f_rvalid !== 3'b000) begin bad++; $display("FAIL rm_release got=%b/%b exp=000", r_rvalid, f_rvalid); end
    tick();
    #1;
    total++; if (r_rvalid !== 3'b000 || f_rvalid !== 3'b000) begin bad++; $display("FAIL rm_after got=%b/%b exp=000", r_rvalid, f_rvalid); end
    req  = 3'b111;
    addr = {32'h10, 32'h10, 32'h10};
    #1;
    total++; if (r_gnt !== 3'b001) begin bad++; $display("FAIL rm_rr_gnt got=%b exp=001", r_gnt); end
    tick();
    idle_inputs();
    #1;
    total++; if (r_rvalid !== 3'b001) begin bad++; $display("FAIL rm_rr_rsp got=%b exp=001", r_rvalid); end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    dev_rdata = {D1, D0};
    idle_inputs();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_unmapped();
    test_decode_write();
    test_dev_error();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
